// File: rtl/mult_booth_ctrl.sv
// Multicycle signed 32x32 radix-2 Booth multiplier: one add/sub step per cycle over 32 cycles.
// Define MULT_OVF_EN to build the 32-bit signed overflow compare; otherwise overflow is tied low.
module mult_booth_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH:0]   p, p_next;
  logic [CNT_W-1:0]   count;
  logic               accept, last;

  logic [WIDTH-1:0]   add_a, y, sum;
  logic               c0, v, s_true;
  logic [3:0]         gg, pp, cc;
  logic               cg;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        accept  = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        if (count == CNT_W'(WIDTH-1)) begin
          state_n = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Booth recode on {Q0, q_1}
  always_comb begin
    add_a = p[2*WIDTH:WIDTH+1];
    case (p[1:0])
      2'b01:   begin y = m_reg;  c0 = 1'b0; end
      2'b10:   begin y = ~m_reg; c0 = 1'b1; end
      default: begin y = '0;     c0 = 1'b0; end
    endcase
  end

  // cla_32: eight 4-bit lookahead groups, group carry passed between them
  always_comb begin
    sum = '0;
    gg  = '0;
    pp  = '0;
    cc  = '0;
    cg  = c0;
    for (int k = 0; k < WIDTH/4; k++) begin
      gg    = add_a[4*k +: 4] & y[4*k +: 4];
      pp    = add_a[4*k +: 4] ^ y[4*k +: 4];
      cc[0] = cg;
      cc[1] = gg[0] | (pp[0] & cg);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cg);
      sum[4*k +: 4] = pp ^ cc;
      cg    = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
            | (pp[3] & pp[2] & pp[1] & pp[0] & cg);
    end
  end

  // sign of the true 33-bit sum, so A never wraps (covers M = most-negative)
  assign v      = (add_a[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != add_a[WIDTH-1]);
  assign s_true = sum[WIDTH-1] ^ v;
  assign p_next = {s_true, sum, p[WIDTH:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      m_reg  <= '0;
      p      <= '0;
      count  <= '0;
      result <= '0;
    end else if (accept) begin
      m_reg  <= multiplicand;
      p      <= {{WIDTH{1'b0}}, multiplier, 1'b0};
      count  <= '0;
    end else if (state == RUN) begin
      p      <= p_next;
      count  <= count + 1'b1;
      if (last) result <= p_next[WIDTH:1];
    end
  end

`ifdef MULT_OVF_EN
  always_ff @(posedge clock) begin
    if (reset)                    overflow <= 1'b0;
    else if (state == RUN && last) overflow <= (p_next[2*WIDTH:WIDTH+1] != {WIDTH{p_next[WIDTH]}});
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl: vector table plus ignored-start and mid-run reset sequences.
module tb_mult_booth_ctrl;

`ifdef MULT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clock, reset, start;
  logic [31:0] multiplicand, multiplier, result;
  logic        busy, result_valid, overflow;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  mult_booth_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .result_valid(result_valid),
    .result(result), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // entered just after a negedge; leaves at the negedge of the IDLE cycle after DONE
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_o);
    int   lat;
    logic seen;
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clock); @(negedge clock);
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("rv_low_at_start", {31'b0, result_valid}, 32'd0);
    seen = 1'b0; lat = 0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clock);
      if (result_valid) begin seen = 1'b1; lat = j; end
    end
    chk("latency", lat, 32'd32);
    chk("result", result, exp_r);
    chk("overflow", {31'b0, overflow}, {31'b0, exp_o & OVF_EN});
    @(negedge clock);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("rv_after_done", {31'b0, result_valid}, 32'd0);
    chk("result_held", result, exp_r);
  endtask

  initial begin
    int pulses;
    logic [31:0] got;

    tbl[0]  = '{32'd3,        32'd5,        32'd15,       1'b0};
    tbl[1]  = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
    tbl[2]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
    tbl[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tbl[4]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    tbl[5]  = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    tbl[6]  = '{32'd12,       32'hFFFFFFF4, 32'hFFFFFF70, 1'b0};
    tbl[7]  = '{32'd0,        32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    tbl[10] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};

    clock = 1'b0; reset = 1'b1; start = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rv", {31'b0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;

    // back-to-back: each op starts in the IDLE cycle right after the previous DONE
    for (int i = 0; i < 11; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ovf);

    // start pulses during RUN must be ignored
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    @(posedge clock);
    pulses = 0; got = '0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clock);
      if (result_valid) begin pulses++; got = result; end
      if (j == 5 || j == 10) begin
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignored_start_pulses", pulses, 32'd1);
    chk("ignored_start_result", got, 32'd81);
    chk("ignored_start_busy", {31'b0, busy}, 32'd0);

    // reset while count==10 aborts the op
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    @(posedge clock);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rv", {31'b0, result_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      if (result_valid || busy) pulses++;
    end
    chk("abort_no_activity", pulses, 32'd0);
    run_op(32'd12, 32'hFFFFFFF4, 32'hFFFFFF70, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
